r_reorder_stage: RTL and testbench
==================================

Name: r_reorder_stage

Overview:
- Reorders R-channel response beats that arrive out of order from downstream AXI slaves.
- Each beat carries a tagid, assigned in request order by the AR-side tag allocator.
- Beats are released strictly in ascending tagid order, with wrap-around, to the outgoing response buffer.
- Sits directly upstream of the outgoing response buffer and drives its r_if slave input.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- DATA_WIDTH, 64, read data width.
- RESP_WIDTH, 2, RRESP width.
- TAG_WIDTH, 4, tag width; slot count NSLOT = 2**TAG_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- in_valid  input  1  response beat from slave side is valid.
- in_ready  output  1  stage accepts the beat.
- in_id  input  ID_WIDTH  AXI ID.
- in_data  input  DATA_WIDTH  read data.
- in_resp  input  RESP_WIDTH  RRESP.
- in_last  input  1  RLAST.
- in_tagid  input  TAG_WIDTH  order tag of the beat.
- out_valid  output  1  in-order beat available.
- out_ready  input  1  outgoing buffer accepts.
- out_id, out_data, out_resp, out_last, out_tagid  output  (widths as inputs)  released beat.
- head_tag  output  TAG_WIDTH  next tag to be released; used by the allocator for its free-slot check.
- occupancy  output  TAG_WIDTH+1  number of slots currently held.
- dup_err  output  1  one-cycle pulse when a beat targets an occupied slot.

Behaviour:
- Storage:
  - NSLOT-entry slot array indexed by tagid; each entry holds {id, data, resp, last}.
  - occ[NSLOT] bitmap; head pointer of TAG_WIDTH bits.
- Reset (rst==0 at posedge):
  - occ cleared, head=0, occupancy=0, dup_err=0.
  - out_valid=0, because occ[head]=0.
  - in_ready=1 after reset.
  - Slot payload is not reset.
  - Reset mid-operation discards all held beats; no partial release follows.
- Input acceptance:
  - in_ready = !occ[in_tagid]. This is combinational on in_tagid; a slot is accepted only if empty.
  - Write occurs when in_valid && in_ready: slot[in_tagid] <= payload, occ[in_tagid] <= 1 at the next edge.
  - When in_valid && occ[in_tagid], the beat is held (backpressure) and dup_err pulses for one cycle. It pulses only on the first cycle of that stall; it rearms when in_valid drops or in_tagid changes.
- Output:
  - out_valid = occ[head]. Payload = slot[head], out_tagid = head.
  - Outputs are driven combinationally from registered state; there is no combinational path from in_* to out_*.
  - Latency: a beat written at edge N is visible on out_* after edge N if its tag equals head.
  - On out_valid && out_ready: occ[head] <= 0, head <= head+1 modulo NSLOT (wraps NSLOT-1 -> 0).
  - Payload stays stable while out_valid && !out_ready.
- Simultaneous events:
  - Release of head and write to a different tag in the same cycle are both performed; occupancy is unchanged.
  - Write to the tag equal to head while head is being released is blocked, because occ is still 1 that cycle. It is accepted on the next cycle.
- occupancy:
  - +1 on write only, -1 on release only, unchanged on both or neither.
  - Range 0..NSLOT; NSLOT means all slots are full.
- Ordering guarantee: out_tagid sequence is exactly 0,1,2,...,NSLOT-1,0,... regardless of arrival order.
- Multi-beat bursts use one tag per beat; in_last is carried through unmodified.

Test Plan:
- Out-of-order fill: with TAG_WIDTH=2, write tags 2,0,3,1 with data 0xA2,0xA0,0xA3,0xA1 and out_ready=1.
  - No output until tag0 arrives.
  - Output order is 0xA0, then 0xA1, 0xA2, 0xA3 back-to-back; head wraps to 0; occupancy returns to 0.
- Backpressure: hold out_ready=0 with tag0 stored.
  - out_valid stays 1 with stable payload for 5 cycles; released on the cycle out_ready=1.
- Duplicate tag: write tag 3, then present tag 3 again.
  - in_ready=0 and dup_err pulses once.
  - Beat is accepted one cycle after slot 3 is released.
- Simultaneous: release head=1 while writing tag 2 in the same cycle.
  - Both take effect and occupancy stays constant.
  - Writing tag 1 during its own release stalls one cycle.
- Full/wrap: fill all 16 slots (default parameters), then drain.
  - occupancy reaches 16, all in_ready=0 at full.
  - Drains 0..15; head returns to 0; a second pass 0..15 works.
- Reset mid-operation: hold 3 beats, drive rst=0 for one edge.
  - out_valid=0, occupancy=0, head_tag=0; no stale beat is released afterwards.

Source files
------------

// File: rtl/r_reorder_stage.sv
// ---------------------------------------------------------------------------
// r_reorder_stage
//
// Purpose:
//   Puts R-channel response beats back into request order. Beats come back
//   from the downstream slaves out of order. Each beat carries the tag that
//   the AR-side allocator gave it. A beat is parked in the slot that its tag
//   selects. Beats leave strictly in ascending tag order, wrapping from
//   NSLOT-1 to 0, towards the outgoing response buffer.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active low
//   in_valid   incoming beat valid
//   in_ready   incoming beat accepted (its target slot is empty)
//   in_id      AXI ID of incoming beat
//   in_data    read data of incoming beat
//   in_resp    RRESP of incoming beat
//   in_last    RLAST of incoming beat (carried through unmodified)
//   in_tagid   order tag of incoming beat
//   out_valid  in-order beat available at the head slot
//   out_ready  downstream buffer accepts the head beat
//   out_id     released beat: AXI ID
//   out_data   released beat: read data
//   out_resp   released beat: RRESP
//   out_last   released beat: RLAST
//   out_tagid  released beat: tag (always equal to head_tag)
//   head_tag   next tag to release; the allocator uses it for its free-slot check
//   occupancy  number of slots currently held (0..NSLOT)
//   dup_err    one-cycle pulse when a beat first stalls on an occupied slot
// ---------------------------------------------------------------------------
module r_reorder_stage #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [RESP_WIDTH-1:0] in_resp,
    input  logic                  in_last,
    input  logic [TAG_WIDTH-1:0]  in_tagid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RESP_WIDTH-1:0] out_resp,
    output logic                  out_last,
    output logic [TAG_WIDTH-1:0]  out_tagid,
    output logic [TAG_WIDTH-1:0]  head_tag,
    output logic [TAG_WIDTH:0]    occupancy,
    output logic                  dup_err
);

    localparam int NSLOT = 1 << TAG_WIDTH;
    localparam int PW    = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

    // Slot payload storage. It is not reset: the occupancy bitmap alone
    // decides whether an entry means anything.
    logic [PW-1:0]        r_slot [NSLOT];
    logic [NSLOT-1:0]     r_occ;
    logic [TAG_WIDTH-1:0] r_head;
    logic [TAG_WIDTH:0]   r_occupancy;
    logic                 r_dup_err;
    logic                 r_stalled;
    logic [TAG_WIDTH-1:0] r_stall_tag;

    logic w_wr;
    logic w_rel;
    logic w_stall;

    // A beat is only accepted into an empty slot. A beat whose tag equals
    // the head that is leaving this cycle therefore waits one cycle: the
    // occupancy bit of the head is still set until the edge.
    assign in_ready = ~r_occ[in_tagid];
    assign w_wr     = in_valid & ~r_occ[in_tagid];
    assign w_stall  = in_valid & r_occ[in_tagid];
    assign w_rel    = r_occ[r_head] & out_ready;

    // The outputs depend only on registered state. There is no path from
    // in_* to out_*.
    assign out_valid = r_occ[r_head];
    assign {out_id, out_data, out_resp, out_last} = r_slot[r_head];
    assign out_tagid = r_head;
    assign head_tag  = r_head;
    assign occupancy = r_occupancy;
    assign dup_err   = r_dup_err;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_slot[in_tagid] <= {in_id, in_data, in_resp, in_last};
        end
    end

    // Per-slot occupancy flags. A write and a release never hit the same
    // slot in one cycle: a write needs the slot empty, a release needs it
    // full.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_occ
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_occ[gi] <= 1'b0;
                end else if (w_wr && (in_tagid == TAG_WIDTH'(gi))) begin
                    r_occ[gi] <= 1'b1;
                end else if (w_rel && (r_head == TAG_WIDTH'(gi))) begin
                    r_occ[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head      <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_rel) begin
                r_head <= r_head + 1'b1;   // natural wrap at NSLOT
            end
            case ({w_wr, w_rel})
                2'b10:   r_occupancy <= r_occupancy + 1'b1;
                2'b01:   r_occupancy <= r_occupancy - 1'b1;
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    // dup_err fires only on the first cycle of a stall. Holding the same
    // beat on the same tag does not fire it again. Dropping in_valid or
    // changing the tag rearms it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dup_err   <= 1'b0;
            r_stalled   <= 1'b0;
            r_stall_tag <= '0;
        end else begin
            r_dup_err   <= w_stall & ~(r_stalled & (r_stall_tag == in_tagid));
            r_stalled   <= w_stall;
            r_stall_tag <= in_tagid;
        end
    end

endmodule

// File: tb/tb_r_reorder_stage.sv
module tb_r_reorder_stage;

    localparam int TW = 4;
    localparam int NS = 16;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_id;
    logic [63:0] in_data;
    logic [1:0]  in_resp;
    logic        in_last;
    logic [3:0]  in_tagid;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [63:0] out_data;
    logic [1:0]  out_resp;
    logic        out_last;
    logic [3:0]  out_tagid;
    logic [3:0]  head_tag;
    logic [4:0]  occupancy;
    logic        dup_err;

    r_reorder_stage #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_data(in_data), .in_resp(in_resp), .in_last(in_last),
        .in_tagid(in_tagid),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_data(out_data), .out_resp(out_resp), .out_last(out_last),
        .out_tagid(out_tagid), .head_tag(head_tag), .occupancy(occupancy),
        .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    // Reference model: the set of held beats keyed by tag, the next tag
    // expected to leave, and the duplicate-pulse expectation.
    pay_t m_store [int];
    int   m_head;
    bit   m_dup;
    bit   m_prev_stall;
    int   m_prev_tag;

    int checks;
    int failures;
    int dup_seen;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, compare the DUT with the model
    // before the edge, then advance the model across the edge.
    task automatic step(input bit v, input int tag, input logic [63:0] d,
                        input bit ordy, input bit rstn);
        bit   wr, rel, stall;
        pay_t p;
        rst       = rstn;
        in_valid  = v;
        in_tagid  = tag[3:0];
        in_data   = d;
        in_id     = 4'($urandom);
        in_resp   = 2'($urandom);
        in_last   = 1'($urandom);
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_store.exists(tag)));
        chk("out_valid", 64'(out_valid), 64'(m_store.exists(m_head)));
        chk("head_tag", 64'(head_tag), 64'(m_head));
        chk("occupancy", 64'(occupancy), 64'(m_store.num()));
        chk("dup_err", 64'(dup_err), 64'(m_dup));
        if (m_store.exists(m_head)) begin
            chk("out_data", out_data, m_store[m_head].data);
            chk("out_id", 64'(out_id), 64'(m_store[m_head].id));
            chk("out_resp", 64'(out_resp), 64'(m_store[m_head].resp));
            chk("out_last", 64'(out_last), 64'(m_store[m_head].last));
            chk("out_tagid", 64'(out_tagid), 64'(m_head));
        end
        if (dup_err === 1'b1) dup_seen++;
        p     = {in_id, in_data, in_resp, in_last};
        stall = v && m_store.exists(tag);
        wr    = v && !m_store.exists(tag);
        rel   = ordy && m_store.exists(m_head);
        @(posedge clk);
        if (!rstn) begin
            m_store.delete();
            m_head       = 0;
            m_dup        = 0;
            m_prev_stall = 0;
            m_prev_tag   = 0;
        end else begin
            if (rel) begin
                $display("release tag=%0d id=%0h data=%h resp=%0d last=%0d",
                         m_head, m_store[m_head].id, m_store[m_head].data,
                         m_store[m_head].resp, m_store[m_head].last);
                m_store.delete(m_head);
                m_head = (m_head + 1) % NS;
            end
            if (wr) m_store[tag] = p;
            m_dup        = stall && !(m_prev_stall && (m_prev_tag == tag));
            m_prev_stall = stall;
            m_prev_tag   = tag;
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, int'($urandom_range(0, NS - 1)), 64'h0, ordy, 1);
    endtask

    initial begin
        int perm [NS];
        int pending [$];
        int alloc_next;
        checks = 0; failures = 0; dup_seen = 0;
        m_head = 0; m_dup = 0; m_prev_stall = 0; m_prev_tag = 0;
        rst = 1'b0; in_valid = 1'b0; in_tagid = '0; in_data = '0;
        in_id = '0; in_resp = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: the first step checks all outputs against an empty model.
        idle(1'b0);

        // Out-of-order fill: no output until tag 0, then in order.
        step(1, 2, 64'hA2, 1, 1);
        step(1, 0, 64'hA0, 1, 1);
        step(1, 3, 64'hA3, 1, 1);
        step(1, 1, 64'hA1, 1, 1);
        repeat (4) idle(1'b1);
        chk("ooo_head", 64'(head_tag), 64'd4);
        chk("ooo_occ", 64'(occupancy), 64'd0);

        // Backpressure: the head beat stays valid and stable for 5 cycles.
        step(1, 4, 64'hB4, 0, 1);
        repeat (5) begin
            idle(1'b0);
            chk("bp_data", out_data, 64'hB4);
        end
        idle(1'b1);

        // Simultaneous release and write to another tag. Then a write to
        // the tag that is leaving, which stalls one cycle.
        step(1, 5, 64'hC5, 0, 1);
        step(1, 6, 64'hC6, 1, 1);
        chk("sim_occ", 64'(occupancy), 64'd1);
        step(1, 6, 64'hD6, 1, 1);
        step(1, 6, 64'hD6, 1, 1);
        idle(1'b0);

        // Duplicate tag: a single dup_err pulse while the stall lasts.
        // The beat is accepted once its slot has been released.
        step(1, 7, 64'hE7, 0, 1);
        step(1, 8, 64'hE8, 0, 1);
        dup_seen = 0;
        repeat (3) step(1, 8, 64'hF8, 0, 1);
        repeat (3) step(1, 8, 64'hF8, 1, 1);
        idle(1'b0);
        chk("dup_pulses", 64'(dup_seen), 64'd1);

        // Reset in the middle of operation while several beats are held.
        step(1, 9, 64'h99, 0, 1);
        step(1, 10, 64'h9A, 0, 1);
        step(1, 12, 64'h9C, 0, 1);
        step(0, 0, 64'h0, 1, 0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_head", 64'(head_tag), 64'd0);
        repeat (4) idle(1'b1);

        // Full and wrap: fill all slots, refuse every tag, then drain.
        for (int t = 0; t < NS; t++) step(1, t, {32'($urandom), 32'($urandom)}, 0, 1);
        chk("full_occ", 64'(occupancy), 64'(NS));
        for (int t = 0; t < NS; t++) begin
            step(0, t, 64'h0, 0, 1);
            chk("full_in_ready", 64'(in_ready), 64'd0);
        end
        repeat (NS) idle(1'b1);
        chk("wrap_head", 64'(head_tag), 64'd0);
        chk("wrap_occ", 64'(occupancy), 64'd0);

        // Second pass: tags arrive in a shuffled order.
        for (int i = 0; i < NS; i++) perm[i] = i;
        for (int i = NS - 1; i > 0; i--) begin
            int j, tmp;
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < NS; i++) step(1, perm[i], {32'($urandom), 32'($urandom)}, 1, 1);
        repeat (NS) idle(1'b1);
        chk("pass2_head", 64'(head_tag), 64'd0);

        // Random traffic: tags are allocated in order within the window and
        // returned out of order, with random downstream backpressure.
        alloc_next = m_head;
        for (int c = 0; c < 600; c++) begin
            if ((pending.size() + m_store.num()) < NS && $urandom_range(0, 3) != 0) begin
                pending.push_back(alloc_next);
                alloc_next = (alloc_next + 1) % NS;
            end
            if (pending.size() > 0 && $urandom_range(0, 2) != 0) begin
                int idx, t;
                idx = int'($urandom_range(0, pending.size() - 1));
                t = pending[idx];
                pending.delete(idx);
                step(1, t, {32'($urandom), 32'($urandom)}, 1'($urandom), 1);
            end else begin
                idle(1'($urandom));
            end
        end
        while (pending.size() > 0) begin
            int t;
            t = pending.pop_front();
            step(1, t, {32'($urandom), 32'($urandom)}, 1, 1);
        end
        repeat (NS + 2) idle(1'b1);
        chk("final_occ", 64'(occupancy), 64'd0);
        chk("final_head", 64'(head_tag), 64'(alloc_next));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
